// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and widths for the data memory responder
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } stateT;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word array, synchronous write, registered read, no reset
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // One access per enable: either commit the write or capture the read word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - request/response memory responder with fixed wait states; DMEM_ERR_CHECK_EN enables address error checking
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              enterResp;
  logic              accept;
  logic              latWe;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic              errQ;
  logic              curWe;
  logic              curErr;
  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curWdata;
  logic [DATA_W-1:0] arrRdata;

  assign accept = req_valid && req_ready;

  // With zero wait states the commit edge is the acceptance edge itself, so the
  // live request must be used there; otherwise the latched copy is used.
  assign curWe    = (state == IDLE) ? req_we    : latWe;
  assign curAddr  = (state == IDLE) ? req_addr  : latAddr;
  assign curWdata = (state == IDLE) ? req_wdata : latWdata;

`ifdef DMEM_ERR_CHECK_EN
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH_WORDS * 4);
  assign curErr  = (curAddr[1:0] != 2'b00) || (curAddr >= ADDR_LIMIT);
  assign rsp_err = (state == RESP) && errQ;
`else
  logic unusedAddrBits;
  assign unusedAddrBits = ^{curAddr[ADDR_W-1:IDX_W+2], curAddr[1:0]};
  assign curErr  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Read data is only meaningful for a clean read; everything else shows zero.
  assign rsp_rdata = ((state == RESP) && !latWe && !errQ) ? arrRdata : '0;

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    enterResp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            stateNext = RESP;
            enterResp = 1'b1;
          end else begin
            stateNext = WAIT;
            cntNext   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          stateNext = RESP;
          enterResp = 1'b1;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request capture on acceptance and error flag capture on the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      errQ     <= 1'b0;
    end else begin
      if (accept) begin
        latWe    <= req_we;
        latAddr  <= req_addr;
        latWdata <= req_wdata;
      end
      if (enterResp) begin
        errQ <= curErr;
      end
    end
  end

  // Errored requests never touch the array.
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) uArray (
    .clk  (clk),
    .en   (enterResp && !curErr),
    .we   (curWe),
    .idx  (curAddr[IDX_W+1:2]),
    .wdata(curWdata),
    .rdata(arrRdata)
  );

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, is the number of 32-bit words stored; it SHALL be a power of two.
REQ-002 Parameter WAIT_STATES, default 2, is the number of extra cycles between request acceptance and the response (0..15).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1: reset; asynchronous, active-low.
REQ-005 Port req_valid, input, 1: the initiator presents a request.
REQ-006 Port req_ready, output, 1: the block accepts a request this cycle.
REQ-007 Port req_we, input, 1: 1 = write, 0 = read.
REQ-008 Port req_addr, input, 32: byte address.
REQ-009 Port req_wdata, input, 32: write data.
REQ-010 Port rsp_valid, output, 1: a response is presented.
REQ-011 Port rsp_ready, input, 1: the initiator takes the response.
REQ-012 Port rsp_rdata, output, 32: read data; 0 for writes and errored requests.
REQ-013 Port rsp_err, output, 1: the request was rejected.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-016 Acceptance is req_valid and req_ready high at a rising edge; on acceptance, req_we, req_addr and req_wdata SHALL be latched.
REQ-017 On acceptance, IDLE SHALL go to WAIT with the counter loaded to WAIT_STATES-1; if WAIT_STATES==0 it SHALL go directly to RESP.
REQ-018 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL go to RESP on the edge where the counter equals 0.
REQ-019 rsp_valid SHALL rise exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-020 Writes SHALL commit to the array, and read data SHALL be registered, on the edge entering RESP; a read SHALL return the contents as of that edge.
REQ-021 In RESP, rsp_rdata and rsp_err SHALL hold stable until rsp_ready is high; that edge SHALL return the FSM to IDLE.
REQ-022 A new request SHALL be accepted no earlier than the cycle after the response handshake; there is no back-to-back overlap.
REQ-023 req_valid asserted outside IDLE SHALL be ignored, with no effect on the array or the outputs.
REQ-024 The word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2].
REQ-025 Read-after-write to the same address SHALL return the new data.

Reset
REQ-026 While rst_n is low, the state SHALL be IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, and the counter 0.
REQ-027 Reset asserted in WAIT SHALL discard the pending request; an uncommitted write SHALL NOT modify the array.
REQ-028 Reset asserted in RESP SHALL drop the response without a handshake.
REQ-029 Array contents are not reset and SHALL be preserved across reset.

Configuration
REQ-030 Macro DMEM_ERR_CHECK_EN defined: a request with req_addr[1:0]!=0 or with req_addr at or beyond DEPTH_WORDS*4 SHALL complete with rsp_err=1, rsp_rdata=0, no array write, and the same latency.
REQ-031 Macro DMEM_ERR_CHECK_EN undefined: rsp_err SHALL be tied to 0, the low two address bits ignored, and upper address bits ignored, so the address wraps modulo DEPTH_WORDS.

Structure
REQ-032 Shared package dmem_pkg SHALL hold the FSM state enum (IDLE/WAIT/RESP), the width constants (DATA_W=32, ADDR_W=32) and the wait-counter width.
REQ-033 Storage SHALL be the sub-module dmem_array: synchronous write, registered read, no reset; the FSM and handshake logic live in the top level.

Verification
REQ-034 Scenario 1: reset, then write 0xDEADBEEF at addr 0x10 with WAIT_STATES=2 -> rsp_valid 3 cycles after acceptance, rsp_err=0.
REQ-035 Scenario 2: read addr 0x10 after Scenario 1 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-036 Scenario 3: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; toggle req_valid meanwhile -> no new acceptance.
REQ-037 Scenario 4: with DMEM_ERR_CHECK_EN, write addr 0x13 and write addr 0x100 (DEPTH 64) -> rsp_err=1 for both, and a read of 0x00 returns its prior value; without the macro, write 0x100 -> a read of 0x00 returns the written data.
REQ-038 Scenario 5: write 0x12345678 at 0x20, pulse rst_n low during WAIT -> state IDLE, rsp_valid=0, and a later read of 0x20 returns the old value.
REQ-039 Scenario 6: WAIT_STATES=0 -> rsp_valid on the cycle after acceptance; back-to-back requests -> one accepted per handshake.
